// File: rtl/flag_unit_stk.sv
// ALU flag unit: derives {C,O,P,N,Z}, masked flag register and a DEPTH-entry LIFO flag stack.
// Optional FLAG_STICKY_OV_EN makes the overflow flag sticky until reset or a restoring pop.
module flag_unit_stk #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] au_out,
  input  logic             c_in,
  input  logic             o_in,
  input  logic             upd,
  input  logic [4:0]       upd_mask,
  input  logic             leq,
  input  logic             push,
  input  logic             pop,
  output logic [4:0]       fu_out,
  output logic             n_out,
  output logic [CNT_W-1:0] stk_cnt,
  output logic             full,
  output logic             empty,
  output logic             stk_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       r_flags;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [4:0]       r_stack [2**IDX_W];

  logic             w_z, w_p, w_n, w_o_new;
  logic [4:0]       w_new, w_upd_flags;
  logic             w_full, w_empty;
  logic             w_do_push, w_do_pop, w_bad_op;
  logic [IDX_W-1:0] w_wr_idx, w_rd_idx;

  always_comb begin
    w_z = (au_out == '0);
    w_p = ~au_out[0];
    w_n = au_out[WIDTH-1] | (w_z & leq);
`ifdef FLAG_STICKY_OV_EN
    w_o_new = r_flags[3] | o_in;
`else
    w_o_new = o_in;
`endif
    w_new       = {c_in, w_o_new, w_p, w_n, w_z};
    w_upd_flags = upd ? ((upd_mask & w_new) | (~upd_mask & r_flags)) : r_flags;
  end

  assign w_full    = (r_cnt == CNT_W'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  // Simultaneous push and pop is a swap no-op on the stack and never an error.
  assign w_do_push = push & ~pop & ~w_full;
  assign w_do_pop  = pop & ~push & ~w_empty;
  assign w_bad_op  = (push & ~pop & w_full) | (pop & ~push & w_empty);
  // Occupied count never exceeds DEPTH, so the low bits address the stack exactly.
  assign w_wr_idx  = r_cnt[IDX_W-1:0];
  assign w_rd_idx  = r_cnt[IDX_W-1:0] - IDX_W'(1);

  always_ff @(posedge ck) begin
    if (rst) begin
      r_flags <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_do_pop) begin
        r_flags <= r_stack[w_rd_idx];
      end else begin
        r_flags <= w_upd_flags;
      end
      if (w_do_push) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_do_pop) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_bad_op) begin
        r_err <= 1'b1;
      end
    end
  end

  // Stack contents need no reset; only r_cnt qualifies them.
  always_ff @(posedge ck) begin
    if (!rst && w_do_push) begin
      r_stack[w_wr_idx] <= r_flags;
    end
  end

  assign fu_out  = r_flags;
  assign n_out   = w_n;
  assign stk_cnt = r_cnt;
  assign full    = w_full;
  assign empty   = w_empty;
  assign stk_err = r_err;

endmodule
